// File: rtl/spi_pkg.sv
// Shared types and widths for the mode-0 SPI master.
// SPI_LSB_FIRST_EN selects LSB-first framing in spi_module.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        END
    } state_t;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int CNT_W = $clog2(DEF_DATA_WIDTH) + 1;
    localparam int DIV_W = 16;

endpackage

// File: rtl/spi_clk_gen.sv
// sck divider for the SPI master: toggles sck every CLK_DIV cycles
// while enabled and flags the edge being produced with a strobe.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    logic [DIV_W-1:0] cnt;
    logic             tick;

    assign tick = cnt == DIV_W'(CLK_DIV - 1);
    // Strobes mark the edge on which sck itself changes.
    assign rise = en && tick && !sck;
    assign fall = en && tick && sck;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_module.sv
// Single-word full-duplex SPI master, mode 0, MSB first by default.
// Define SPI_LSB_FIRST_EN to shift LSB first on both mosi and miso.
module spi_module
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sdo_valid_i,
    output logic                  sdo_ready_o,
    input  logic [DATA_WIDTH-1:0] sdo_data_i,
    output logic                  sdi_valid_o,
    input  logic                  sdi_ready_i,
    output logic [DATA_WIDTH-1:0] sdi_data_o,
    output logic                  sck_o,
    output logic                  cs_n_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
    logic [DATA_WIDTH-1:0] tx_shift, rx_shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      cnt;
    logic                  tx_first, tx_next;
    logic                  cnt_done, last_bit;
    logic                  accept, done;
    logic                  rise, fall;

`ifdef SPI_LSB_FIRST_EN
    assign tx_first = sdo_data_i[0];
    assign tx_next  = tx_sr[1];
    assign tx_shift = tx_sr >> 1;
    assign rx_shift = {miso_i, rx_sr[DATA_WIDTH-1:1]};
`else
    assign tx_first = sdo_data_i[DATA_WIDTH-1];
    assign tx_next  = tx_sr[DATA_WIDTH-2];
    assign tx_shift = tx_sr << 1;
    assign rx_shift = {rx_sr[DATA_WIDTH-2:0], miso_i};
`endif

    assign cnt_done = cnt == DIV_W'(CLK_DIV - 1);
    assign last_bit = bit_cnt == CNT_W'(DATA_WIDTH - 1);
    assign accept   = state == IDLE && sdo_valid_i && sdo_ready_o;
    assign done     = state == END && cnt_done;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk (clk),
        .rst (rst),
        .en  (state == SHIFT),
        .sck (sck_o),
        .rise(rise),
        .fall(fall)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = SETUP;
            SETUP: if (cnt_done) state_nx = SHIFT;
            SHIFT: if (fall && last_bit) state_nx = END;
            END:   if (cnt_done) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sdo_ready_o <= 1'b1;
            cs_n_o      <= 1'b1;
            mosi_o      <= 1'b0;
            sdi_valid_o <= 1'b0;
            sdi_data_o  <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            cnt         <= '0;
        end else begin
            // cnt times SETUP and END; it restarts on every state change
            cnt         <= (state_nx != state) ? '0 : cnt + 1'b1;
            sdo_ready_o <= state_nx == IDLE;
            cs_n_o      <= state_nx == IDLE;
            if (accept) begin
                tx_sr   <= sdo_data_i;
                mosi_o  <= tx_first;
                rx_sr   <= '0;
                bit_cnt <= '0;
            end
            if (rise) rx_sr <= rx_shift;
            if (fall) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (!last_bit) begin
                    tx_sr  <= tx_shift;
                    mosi_o <= tx_next;
                end
            end
            // A completing frame wins over a consumer draining the old word
            if (done) begin
                sdi_valid_o <= 1'b1;
                sdi_data_o  <= rx_sr;
            end else if (sdi_ready_i) begin
                sdi_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_module.sv
// Directed bench for spi_module: default build plus a CLK_DIV=3 instance.
module tb_spi_module;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdo_valid = 1'b0;
    logic        sdo_ready;
    logic [23:0] sdo_data = '0;
    logic        sdi_valid;
    logic        sdi_ready = 1'b0;
    logic [23:0] sdi_data;
    logic        sck, cs_n, mosi, miso;
    logic        miso_val = 1'b0;
    logic        loop = 1'b0;

    logic        v3 = 1'b0;
    logic        rdy3;
    logic [23:0] d3 = '0;
    logic        sv3;
    logic [23:0] sd3;
    logic        sck3, cs3, mosi3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign miso = loop ? mosi : miso_val;

    spi_module dut (
        .clk        (clk),
        .rst        (rst),
        .sdo_valid_i(sdo_valid),
        .sdo_ready_o(sdo_ready),
        .sdo_data_i (sdo_data),
        .sdi_valid_o(sdi_valid),
        .sdi_ready_i(sdi_ready),
        .sdi_data_o (sdi_data),
        .sck_o      (sck),
        .cs_n_o     (cs_n),
        .mosi_o     (mosi),
        .miso_i     (miso)
    );

    spi_module #(.CLK_DIV(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .sdo_valid_i(v3),
        .sdo_ready_o(rdy3),
        .sdo_data_i (d3),
        .sdi_valid_o(sv3),
        .sdi_ready_i(1'b0),
        .sdi_data_o (sd3),
        .sck_o      (sck3),
        .cs_n_o     (cs3),
        .mosi_o     (mosi3),
        .miso_i     (mosi3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from idle; returns mosi bits seen at sck rises,
    // cs_n low time and sck pulse count. Optional mid-frame poke of
    // sdo_valid and sdi_ready raised for the completion edge.
    task automatic run_frame(input logic [23:0] tx, input bit poke,
                             input bit rdy_end,
                             output logic [23:0] bits,
                             output int low, output int pulses);
        logic prev;
        bits   = '0;
        low    = 0;
        pulses = 0;
        prev   = 1'b0;
        sdo_data  = tx;
        sdo_valid = 1'b1;
        step();
        sdo_valid = 1'b0;
        while (!cs_n && low < 200) begin
            low++;
            if (poke && low == 10) begin
                sdo_data  = 24'h111111;
                sdo_valid = 1'b1;
            end
            if (poke && low == 11) sdo_valid = 1'b0;
            if (rdy_end && low == 50) sdi_ready = 1'b1;
            step();
            if (sck && !prev) begin
                pulses++;
                bits = {bits[22:0], mosi};
            end
            prev = sck;
        end
    endtask

    initial begin
        logic [23:0] bits;
        int low, pulses, rises, g, r1, r2;
        logic prev;

        step();
        step();
        rst = 1'b0;
        check("rst_ready", sdo_ready, 1);
        check("rst_cs_n", cs_n, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_sdi_valid", sdi_valid, 0);
        check("rst_sdi_data", sdi_data, 0);

        // Basic TX with miso low
        run_frame(24'h0000AB, 0, 0, bits, low, pulses);
        check("basic_mosi", bits, 24'h0000AB);
        check("basic_cs_low", low, 50);
        check("basic_pulses", pulses, 24);
        check("basic_valid", sdi_valid, 1);
        check("basic_data", sdi_data, 24'h000000);
        check("basic_ready", sdo_ready, 1);
        sdi_ready = 1'b1;
        step();
        sdi_ready = 1'b0;
        check("basic_consumed", sdi_valid, 0);

        // Loopback
        loop = 1'b1;
        run_frame(24'hA5C3F0, 0, 0, bits, low, pulses);
        loop = 1'b0;
        check("loop_mosi", bits, 24'hA5C3F0);
        check("loop_data", sdi_data, 24'hA5C3F0);
        check("loop_valid", sdi_valid, 1);
        sdi_ready = 1'b1;
        step();
        sdi_ready = 1'b0;

        // All ones received; valid holds until consumed
        miso_val = 1'b1;
        run_frame(24'h123456, 0, 0, bits, low, pulses);
        check("ones_data", sdi_data, 24'hFFFFFF);
        step();
        step();
        step();
        check("ones_hold_valid", sdi_valid, 1);
        check("ones_hold_data", sdi_data, 24'hFFFFFF);
        sdi_ready = 1'b1;
        check("ones_pre_edge", sdi_valid, 1);
        step();
        sdi_ready = 1'b0;
        check("ones_cleared", sdi_valid, 0);

        // Busy poke ignored, then overflow overwrite
        run_frame(24'h5A5A5A, 1, 0, bits, low, pulses);
        check("busy_mosi", bits, 24'h5A5A5A);
        check("busy_cs_low", low, 50);
        check("busy_data", sdi_data, 24'hFFFFFF);
        step();
        step();
        check("busy_no_frame", cs_n, 1);
        miso_val = 1'b0;
        run_frame(24'h00FF00, 0, 0, bits, low, pulses);
        check("ovf_data", sdi_data, 24'h000000);
        check("ovf_valid", sdi_valid, 1);

        // Completion and consume on the same edge: new word wins
        loop = 1'b1;
        run_frame(24'h3C3C3C, 0, 1, bits, low, pulses);
        check("race_valid", sdi_valid, 1);
        check("race_data", sdi_data, 24'h3C3C3C);
        step();
        sdi_ready = 1'b0;
        check("race_cleared", sdi_valid, 0);

        // Reset at bit 10 with a word pending
        run_frame(24'h0F0F0F, 0, 0, bits, low, pulses);
        check("pre_rst_valid", sdi_valid, 1);
        sdo_data  = 24'h0000AB;
        sdo_valid = 1'b1;
        step();
        sdo_valid = 1'b0;
        rises = 0;
        g     = 0;
        prev  = 1'b0;
        while (rises < 10 && g < 200) begin
            step();
            if (sck && !prev) rises++;
            prev = sck;
            g++;
        end
        check("rst_mid_bit", rises, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_cs_n", cs_n, 1);
        check("rst_mid_sck", sck, 0);
        check("rst_mid_ready", sdo_ready, 1);
        check("rst_mid_valid", sdi_valid, 0);
        run_frame(24'h0000AB, 0, 0, bits, low, pulses);
        loop = 1'b0;
        check("post_rst_mosi", bits, 24'h0000AB);
        check("post_rst_cs_low", low, 50);
        check("post_rst_data", sdi_data, 24'h0000AB);

        // CLK_DIV=3 instance, loopback
        d3 = 24'h123456;
        v3 = 1'b1;
        step();
        v3 = 1'b0;
        low  = 0;
        r1   = -1;
        r2   = -1;
        prev = 1'b0;
        while (!cs3 && low < 500) begin
            low++;
            step();
            if (sck3 && !prev) begin
                if (r1 < 0) r1 = low;
                else if (r2 < 0) r2 = low;
            end
            prev = sck3;
        end
        check("div3_cs_low", low, 150);
        check("div3_period", r2 - r1, 6);
        check("div3_data", sd3, 24'h123456);
        check("div3_valid", sv3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/spi_module.md
Name: spi_module

Overview:
Single-word, full-duplex SPI master, mode 0 (CPOL=0, CPHA=0), MSB first by default. A parallel TX word is accepted through a valid/ready handshake and shifted out on mosi_o. The word shifted in on miso_i in the same frame is presented through a valid/ready output handshake. It sits between on-chip control logic and an external SPI slave, such as sensor configuration registers.

Parameters:
DATA_WIDTH, 24, bits per frame; equals the width of sdo_data_i and sdi_data_o.
CLK_DIV, 1, sck half-period in clk cycles (≥1); sck frequency = clk / (2·CLK_DIV).

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
sdo_valid_i  input  1  TX word valid
sdo_ready_o  output  1  block idle, can accept a TX word
sdo_data_i  input  DATA_WIDTH  TX word
sdi_valid_o  output  1  RX word valid
sdi_ready_i  input  1  consumer accepts the RX word
sdi_data_o  output  DATA_WIDTH  RX word
sck_o  output  1  SPI clock, idle low
cs_n_o  output  1  SPI chip select, active low
mosi_o  output  1  serial data out
miso_i  input  1  serial data in

Behaviour:
- Only one clock and one reset are used. Reset is synchronous and active-high.
- Reset values:
  - sdo_ready_o=1, cs_n_o=1, sck_o=0, mosi_o=0.
  - sdi_valid_o=0, sdi_data_o=0.
  - State = IDLE; all counters and shift registers are cleared.
- All outputs are registered.
- FSM states: IDLE → SETUP → SHIFT → END → IDLE.
- IDLE:
  - sdo_ready_o=1, cs_n_o=1, sck_o=0.
  - A TX word is accepted when sdo_valid_i && sdo_ready_o at a rising edge. The block latches sdo_data_i into the TX shift register and moves to SETUP.
  - sdo_ready_o drops on the next cycle. sdo_valid_i is ignored while not in IDLE.
- SETUP:
  - cs_n_o=0 and mosi_o = TX bit DATA_WIDTH-1.
  - The block holds for CLK_DIV cycles, then moves to SHIFT.
- SHIFT:
  - sck_o toggles every CLK_DIV cycles, giving DATA_WIDTH full pulses.
  - On each sck rising transition, miso_i is shifted into the RX register LSB (RX register shifts left).
  - On each sck falling transition, except the last, mosi_o advances to the next lower bit.
  - After the DATA_WIDTH-th falling transition (sck_o back to 0), the block moves to END.
- END:
  - cs_n_o stays 0 for CLK_DIV cycles.
  - Then: cs_n_o=1, sdi_data_o ← RX register, sdi_valid_o=1, state=IDLE, sdo_ready_o=1.
- Frame timing:
  - cs_n_o is low for (2·DATA_WIDTH+2)·CLK_DIV cycles, i.e. 50 cycles at the defaults.
  - sdi_valid_o rises on the same edge that cs_n_o deasserts.
- RX handshake:
  - sdi_valid_o stays high until a cycle with sdi_ready_i=1, and clears on the following edge.
  - sdi_data_o is stable while sdi_valid_o=1.
  - If a new frame completes while sdi_valid_o is still high, sdi_data_o is overwritten and sdi_valid_o stays 1. Overflow is not flagged.
  - If a frame completes in the same cycle that sdi_ready_i consumes the old word, the new word wins and sdi_valid_o=1.
- TX and RX handshakes are independent; a new frame may start while a received word is still pending.
- rst during a frame: on the next edge the block returns to IDLE, cs_n_o=1 and sck_o=0. The partial frame is discarded and sdi_valid_o=0.
- A back-to-back sdo_valid_i held high starts the next frame on the first IDLE cycle. cs_n_o is therefore high for at least 1 cycle between frames.

Optional Feature:
SPI_LSB_FIRST_EN:
- Defined: mosi_o transmits bit 0 first, and miso_i bits fill the RX register from the MSB downward (RX register shifts right). sdi_data_o bit i is therefore the i-th received bit.
- Undefined: MSB-first, as described in Behaviour.
- Timing is identical in both builds.

Decomposition:
- Shared package spi_pkg holds:
  - state enum: IDLE, SETUP, SHIFT, END;
  - localparam CNT_W = $clog2(DATA_WIDTH)+1 for the bit counter;
  - localparam DIV_W for the divider counter.
- One sub-module, spi_clk_gen: a divider that emits sck_o plus one-cycle rise/fall strobes, enabled in SHIFT.
- The FSM, shift registers and handshakes stay in spi_module.

Test Plan:
- Basic TX: sdo_data_i=24'h0000AB, pulse sdo_valid_i, miso_i=0.
  - mosi_o sampled on sck rises = 16 zeros then 1,0,1,0,1,0,1,1.
  - cs_n_o low exactly 50 cycles; sck_o shows 24 pulses.
  - sdi_valid_o=1 with sdi_data_o=24'h000000.
- Loopback: miso_i tied to mosi_o, sdo_data_i=24'hA5C3F0 → sdi_data_o=24'hA5C3F0.
- RX all ones: miso_i=1, any TX word → sdi_data_o=24'hFFFFFF. sdi_valid_o stays high until sdi_ready_i=1, then clears the next cycle.
- Busy and overflow:
  - Pulse sdo_valid_i with 24'h111111 mid-frame → ignored.
  - With sdi_ready_i=0, run two frames (miso_i=1, then miso_i=0) → sdi_data_o=24'h000000 with sdi_valid_o still 1.
- Reset mid-frame: assert rst at bit 10 → next edge cs_n_o=1, sck_o=0, sdo_ready_o=1, sdi_valid_o=0. A new frame of 24'h0000AB then completes normally.
- CLK_DIV=3 build: sck period is 6 clk and cs_n_o is low 150 cycles; loopback of 24'h123456 is correct.
